nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that processes operands one 4-bit nibble per clock, least-significant nibble first, carry chained through a register.
- Sits between a register-file/operand source upstream and any result consumer downstream, with valid/ready on both sides.
- Intended for area-constrained datapaths where a full-width ripple adder is too large.
- Result is a WIDTH-bit sum plus carry-out.

---
 rtl/nibble_serial_adder_pkg.sv | 13 +
 rtl/nibble_add_ci.sv | 22 ++
 rtl/nibble_serial_adder.sv | 108 ++++++++++
 tb/tb_nibble_serial_adder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional signed-overflow output: NIBBLE_SERIAL_ADDER_OVF_EN.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/nibble_add_ci.sv
// Combinational 4-bit adder with carry-in and carry-out.
// One nibble slice of the serial adder datapath.
module nibble_add_ci
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             c_i,
    output logic [NIB_W-1:0] s_o,
    output logic             c_o
);

    logic [NIB_W:0] sum;

    assign sum = (NIB_W+1)'(a_i)
               + (NIB_W+1)'(b_i)
               + (NIB_W+1)'(c_i);

    assign s_o = sum[NIB_W-1:0];
    assign c_o = sum[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder, one nibble per clock, LS nibble first.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the ovf_o port.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_q;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic [NIB_W-1:0] nsum;
    logic             ncy;

    nibble_add_ci u_add (
        .a_i (a_sh[NIB_W-1:0]),
        .b_i (b_sh[NIB_W-1:0]),
        .c_i (cy),
        .s_o (nsum),
        .c_o (ncy)
    );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && in_valid_i) begin
            a_msb <= a_i[WIDTH-1];
            b_msb <= b_i[WIDTH-1];
        end
    end

    // Operand signs are frozen until the next accept, so this holds with s_o.
    assign ovf_o = (a_msb == b_msb) & (s_q[WIDTH-1] != a_msb);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_q   <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_sh  <= a_i;
                        b_sh  <= b_i;
                        cy    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> NIB_W;
                    b_sh <= b_sh >> NIB_W;
                    s_q  <= {nsum, s_q[WIDTH-1:NIB_W]};
                    cy   <= ncy;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign s_o         = s_q;
    assign c_o         = cy;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder, WIDTH=16.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to also check ovf_o.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf;
`endif

    int compared = 0;
    int mismatched = 0;
    int n;
    int ii;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .s_o         (s),
        .c_o         (c)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] av, input logic [15:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'h0);
        chk("rst_c", 32'(c), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic add and latency
        out_ready = 1'b1;
        start(16'h1234, 16'h4321);
        chk("t1_busy", 32'(in_ready), 32'd0);
        wait_valid(n);
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_s", 32'(s), 32'h5555);
        chk("t1_c", 32'(c), 32'd0);
        tick();
        chk("t1_idle", 32'(in_ready), 32'd1);

        // 2: full carry ripple
        start(16'hFFFF, 16'h0001);
        wait_valid(n);
        chk("t2_latency", 32'(n), 32'd4);
        chk("t2_s", 32'(s), 32'h0000);
        chk("t2_c", 32'(c), 32'd1);
        tick();

        // 3: backpressure in DONE, inputs ignored
        out_ready = 1'b0;
        start(16'h00FF, 16'h0001);
        wait_valid(n);
        chk("t3_latency", 32'(n), 32'd4);
        a = 16'hAAAA;
        b = 16'h1111;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_ready", 32'(in_ready), 32'd0);
            chk("t3_hold_s", 32'(s), 32'h0100);
            chk("t3_hold_c", 32'(c), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_idle_ready", 32'(in_ready), 32'd1);
        chk("t3_idle_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t3_no_capture", 32'(in_ready), 32'd1);

        // 4: async reset mid-RUN
        start(16'h1111, 16'h2222);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(out_valid), 32'd0);
        chk("t4_rst_ready", 32'(in_ready), 32'd1);
        chk("t4_rst_s", 32'(s), 32'h0);
        chk("t4_rst_c", 32'(c), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start(16'h0F0F, 16'h0101);
        wait_valid(n);
        chk("t4_latency", 32'(n), 32'd4);
        chk("t4_s", 32'(s), 32'h1010);
        chk("t4_c", 32'(c), 32'd0);
        tick();

        // 5: back-to-back with in_valid held
        a = 16'h8000;
        b = 16'h8000;
        in_valid = 1'b1;
        tick();
        a = 16'h0001;
        b = 16'h0002;
        wait_valid(n);
        ii = n;
        chk("t5a_latency", 32'(n), 32'd4);
        chk("t5a_s", 32'(s), 32'h0000);
        chk("t5a_c", 32'(c), 32'd1);
        tick();
        ii++;
        chk("t5_idle_ready", 32'(in_ready), 32'd1);
        tick();
        ii++;
        chk("t5_accept", 32'(in_ready), 32'd0);
        chk("t5_ii", 32'(ii), 32'd6);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t5b_latency", 32'(n), 32'd4);
        chk("t5b_s", 32'(s), 32'h0003);
        chk("t5b_c", 32'(c), 32'd0);
        tick();

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        // 6: signed overflow flag
        start(16'h7FFF, 16'h0001);
        wait_valid(n);
        chk("t6a_s", 32'(s), 32'h8000);
        chk("t6a_ovf", 32'(ovf), 32'd1);
        chk("t6a_c", 32'(c), 32'd0);
        tick();
        start(16'h8000, 16'h8000);
        wait_valid(n);
        chk("t6b_ovf", 32'(ovf), 32'd1);
        chk("t6b_c", 32'(c), 32'd1);
        tick();
        start(16'hFFFF, 16'h0001);
        wait_valid(n);
        chk("t6c_ovf", 32'(ovf), 32'd0);
        chk("t6c_c", 32'(c), 32'd1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
